// File: rtl/dac_output_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// dac_output_scheduler_pkg
// Shared definitions for the DAC output scheduler:
//   - FSM state encodings (legacy-compatible 2-bit constants)
//   - width of the optional coalesced-write counter and its saturating step
// Optional feature macro used by the top: DAC_SCHED_OVWR_CNT_EN
// ---------------------------------------------------------------------------
package dac_output_scheduler_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    localparam int OVWR_W = 16;

    function automatic logic [OVWR_W-1:0] sat_inc(input logic [OVWR_W-1:0] v);
        return (v == '1) ? v : v + OVWR_W'(1);
    endfunction

endpackage

// File: rtl/dac_output_scheduler_rr_pending_select.sv
// ---------------------------------------------------------------------------
// rr_pending_select
// Combinational round-robin picker: returns the first pending channel
// strictly after rr_ptr, wrapping N_CHAN-1 -> 0.
// Ports:
//   pend      in   N_CHAN   pending flag per channel
//   rr_ptr    in   W_CHAN   last issued channel
//   sel       out  W_CHAN   selected channel (valid when any_pend)
//   any_pend  out  1        at least one channel pending
// ---------------------------------------------------------------------------
module rr_pending_select #(
    parameter int N_CHAN = 8,
    parameter int W_CHAN = 3
) (
    input  logic [N_CHAN-1:0] pend,
    input  logic [W_CHAN-1:0] rr_ptr,
    output logic [W_CHAN-1:0] sel,
    output logic              any_pend
);

    logic [W_CHAN-1:0] idx;

    // Scan from the farthest candidate to the nearest so the last hit,
    // i.e. the one closest after rr_ptr, wins without a found flag.
    always_comb begin
        sel = rr_ptr;
        idx = '0;
        for (int i = N_CHAN; i >= 1; i--) begin
            idx = W_CHAN'((int'(rr_ptr) + i) % N_CHAN);
            if (|(pend & (N_CHAN'(1) << idx))) begin
                sel = idx;
            end
        end
    end

    assign any_pend = |pend;

endmodule

// File: rtl/dac_output_scheduler.sv
// ---------------------------------------------------------------------------
// dac_output_scheduler
// One coalescing slot per DAC channel (newest value wins). Pending slots are
// issued round-robin to the DAC controller, one at a time, each handshaked on
// dac_done_in with a watchdog. Host writes beat PID writes on the same
// channel; channels in hold_mask_in ignore PID writes.
//
// state | meaning
// IDLE  | waiting for any pending slot; issues one when found
// ISSUE | issue strobe cycle; watchdog cleared
// WAIT  | waiting for dac_done_in or watchdog expiry
//
// Ports:
//   clk_in, rst_in (async, active-low)
//   pid_dv_in/pid_chan_in/pid_data_in      PID write
//   host_dv_in/host_chan_in/host_data_in   host write (priority)
//   hold_mask_in                           per-channel PID discard
//   dac_dv_out/dac_chan_out/dac_data_out   issue to DAC controller
//   dac_done_in                            controller write complete
//   busy_out                               high in ISSUE or WAIT
//   tmo_out                                sticky watchdog expiry
//   ovwr_cnt_out                           only with DAC_SCHED_OVWR_CNT_EN:
//                                          saturating coalesced-drop count
// ---------------------------------------------------------------------------
module dac_output_scheduler
    import dac_output_scheduler_pkg::*;
#(
    parameter int N_CHAN = 8,
    parameter int W_CHAN = 3,
    parameter int W_DATA = 16,
    parameter int W_TMO  = 10
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              pid_dv_in,
    input  logic [W_CHAN-1:0] pid_chan_in,
    input  logic [W_DATA-1:0] pid_data_in,
    input  logic              host_dv_in,
    input  logic [W_CHAN-1:0] host_chan_in,
    input  logic [W_DATA-1:0] host_data_in,
    input  logic [N_CHAN-1:0] hold_mask_in,
    output logic              dac_dv_out,
    output logic [W_CHAN-1:0] dac_chan_out,
    output logic [W_DATA-1:0] dac_data_out,
    input  logic              dac_done_in,
    output logic              busy_out,
    output logic              tmo_out
`ifdef DAC_SCHED_OVWR_CNT_EN
    ,
    output logic [OVWR_W-1:0] ovwr_cnt_out
`endif
);

    logic [1:0]        state;
    logic [N_CHAN-1:0] pend;
    logic [W_DATA-1:0] val [N_CHAN];
    logic [W_CHAN-1:0] rr_ptr;
    logic [W_TMO-1:0]  wd_cnt;
    logic [W_TMO-1:0]  wd_next;
    logic [W_CHAN-1:0] sel;
    logic              any_pend;
    logic [N_CHAN-1:0] pid_hit;
    logic [N_CHAN-1:0] host_hit;
    logic [N_CHAN-1:0] wr_hit;
    logic [N_CHAN-1:0] issue_clr;
    logic [W_DATA-1:0] sel_data;

    rr_pending_select #(
        .N_CHAN (N_CHAN),
        .W_CHAN (W_CHAN)
    ) u_rr_pending_select (
        .pend     (pend),
        .rr_ptr   (rr_ptr),
        .sel      (sel),
        .any_pend (any_pend)
    );

    // Per-channel decode; channel indices >= N_CHAN match nothing.
    always_comb begin
        pid_hit  = '0;
        host_hit = '0;
        sel_data = '0;
        for (int c = 0; c < N_CHAN; c++) begin
            pid_hit[c]  = pid_dv_in && (int'(pid_chan_in) == c) && !hold_mask_in[c];
            host_hit[c] = host_dv_in && (int'(host_chan_in) == c);
            if (int'(sel) == c) begin
                sel_data = val[c];
            end
        end
    end

    assign wr_hit    = pid_hit | host_hit;
    assign issue_clr = (state == S_IDLE && any_pend) ? (N_CHAN'(1) << sel) : '0;
    assign wd_next   = wd_cnt + W_TMO'(1);
    assign busy_out  = (state == S_ISSUE) || (state == S_WAIT);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state        <= S_IDLE;
            pend         <= '0;
            rr_ptr       <= W_CHAN'(N_CHAN - 1);
            wd_cnt       <= '0;
            dac_dv_out   <= 1'b0;
            dac_chan_out <= '0;
            dac_data_out <= '0;
            tmo_out      <= 1'b0;
            for (int c = 0; c < N_CHAN; c++) begin
                val[c] <= '0;
            end
        end else begin
            // A write landing on the slot being issued re-arms it, so the
            // newer value goes out on a later round.
            pend <= (pend & ~issue_clr) | wr_hit;
            for (int c = 0; c < N_CHAN; c++) begin
                if (host_hit[c]) begin
                    val[c] <= host_data_in;
                end else if (pid_hit[c]) begin
                    val[c] <= pid_data_in;
                end
            end

            case (state)
                S_IDLE: begin
                    if (any_pend) begin
                        dac_chan_out <= sel;
                        dac_data_out <= sel_data;
                        rr_ptr       <= sel;
                        dac_dv_out   <= 1'b1;
                        state        <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    dac_dv_out <= 1'b0;
                    wd_cnt     <= '0;
                    state      <= S_WAIT;
                end
                S_WAIT: begin
                    if (dac_done_in) begin
                        state <= S_IDLE;
                    end else begin
                        wd_cnt <= wd_next;
                        if (wd_next == '1) begin
                            tmo_out <= 1'b1;
                            state   <= S_IDLE;
                        end
                    end
                end
                default: begin
                    dac_dv_out <= 1'b0;
                    state      <= S_IDLE;
                end
            endcase
        end
    end

`ifdef DAC_SCHED_OVWR_CNT_EN
    // A same-cycle host+PID pair on one channel is a single coalesce event;
    // the slot being issued this cycle is not a drop.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            ovwr_cnt_out <= '0;
        end else if (|(wr_hit & pend & ~issue_clr)) begin
            ovwr_cnt_out <= sat_inc(ovwr_cnt_out);
        end
    end
`endif

endmodule

// File: tb/tb_dac_output_scheduler.sv
`timescale 1ns/1ps
module tb_dac_output_scheduler;

    localparam int N_CHAN   = 8;
    localparam int W_CHAN   = 4;
    localparam int W_DATA   = 16;
    localparam int W_TMO    = 10;
    localparam int TMO_WAIT = (1 << W_TMO) - 1;

    logic              clk_in = 1'b0;
    logic              rst_in;
    logic              pid_dv_in = 1'b0;
    logic [W_CHAN-1:0] pid_chan_in = '0;
    logic [W_DATA-1:0] pid_data_in = '0;
    logic              host_dv_in = 1'b0;
    logic [W_CHAN-1:0] host_chan_in = '0;
    logic [W_DATA-1:0] host_data_in = '0;
    logic [N_CHAN-1:0] hold_mask_in = '0;
    logic              dac_done_in = 1'b0;
    logic              dac_dv_out;
    logic [W_CHAN-1:0] dac_chan_out;
    logic [W_DATA-1:0] dac_data_out;
    logic              busy_out;
    logic              tmo_out;
`ifdef DAC_SCHED_OVWR_CNT_EN
    logic [15:0]       ovwr_cnt_out;
`endif

    int total = 0;
    int bad   = 0;
    bit started = 0;
    int iss_chan[$];
    int iss_data[$];

    always #5 clk_in = ~clk_in;

    dac_output_scheduler #(
        .N_CHAN (N_CHAN),
        .W_CHAN (W_CHAN),
        .W_DATA (W_DATA),
        .W_TMO  (W_TMO)
    ) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .pid_dv_in    (pid_dv_in),
        .pid_chan_in  (pid_chan_in),
        .pid_data_in  (pid_data_in),
        .host_dv_in   (host_dv_in),
        .host_chan_in (host_chan_in),
        .host_data_in (host_data_in),
        .hold_mask_in (hold_mask_in),
        .dac_dv_out   (dac_dv_out),
        .dac_chan_out (dac_chan_out),
        .dac_data_out (dac_data_out),
        .dac_done_in  (dac_done_in),
        .busy_out     (busy_out),
        .tmo_out      (tmo_out)
`ifdef DAC_SCHED_OVWR_CNT_EN
        ,
        .ovwr_cnt_out (ovwr_cnt_out)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Slots, pending flags, last-issued pointer, and "cycles since issue"
    // (-1 when nothing is outstanding).
    logic [W_DATA-1:0] m_val [N_CHAN];
    bit [N_CHAN-1:0]   m_pend;
    int                m_rr, m_since, m_chan, m_data, m_ovwr;
    bit                m_dv, m_tmo, m_iss, m_pa, m_ha, m_ov;
    int                m_c, m_pc, m_hc;

    always @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int c = 0; c < N_CHAN; c++) m_val[c] = '0;
            m_pend = '0; m_rr = N_CHAN - 1; m_since = -1;
            m_dv = 0; m_chan = 0; m_data = 0; m_tmo = 0; m_ovwr = 0;
        end else begin
            m_iss = 0;
            if (m_since < 0) begin
                for (int k = 1; k <= N_CHAN; k++) begin
                    m_c = (m_rr + k) % N_CHAN;
                    if (!m_iss && m_pend[m_c]) begin
                        m_iss = 1; m_chan = m_c; m_data = int'(m_val[m_c]);
                        m_pend[m_c] = 0; m_rr = m_c;
                    end
                end
            end else if (m_since >= 1 && dac_done_in) begin
                m_since = -1;
            end else begin
                m_since++;
                if (m_since == TMO_WAIT + 1) begin
                    m_tmo = 1; m_since = -1;
                end
            end
            if (m_iss) m_since = 0;
            m_dv = m_iss;

            m_pc = int'(pid_chan_in);
            m_hc = int'(host_chan_in);
            m_pa = 0;
            if (pid_dv_in && m_pc < N_CHAN) m_pa = !hold_mask_in[pid_chan_in[2:0]];
            m_ha = host_dv_in && (m_hc < N_CHAN);
            m_ov = (m_pa && m_pend[m_pc % N_CHAN]) || (m_ha && m_pend[m_hc % N_CHAN]);
            if (m_pa) begin m_val[m_pc] = pid_data_in;  m_pend[m_pc] = 1; end
            if (m_ha) begin m_val[m_hc] = host_data_in; m_pend[m_hc] = 1; end
            if (m_ov && m_ovwr < 65535) m_ovwr++;
        end
    end

    always @(negedge clk_in) begin
        if (started) begin
            chk("cyc_dv",   32'(dac_dv_out),   32'(m_dv));
            chk("cyc_chan", 32'(dac_chan_out), 32'(m_chan));
            chk("cyc_data", 32'(dac_data_out), 32'(m_data));
            chk("cyc_busy", 32'(busy_out),     32'(m_since >= 0));
            chk("cyc_tmo",  32'(tmo_out),      32'(m_tmo));
`ifdef DAC_SCHED_OVWR_CNT_EN
            chk("cyc_ovwr", 32'(ovwr_cnt_out), 32'(m_ovwr));
`endif
            if (dac_dv_out === 1'b1) begin
                iss_chan.push_back(int'(dac_chan_out));
                iss_data.push_back(int'(dac_data_out));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic pid_wr(input int ch, input int d);
        pid_dv_in = 1; pid_chan_in = W_CHAN'(ch); pid_data_in = W_DATA'(d);
        tick(1);
        pid_dv_in = 0;
    endtask

    task automatic host_wr(input int ch, input int d);
        host_dv_in = 1; host_chan_in = W_CHAN'(ch); host_data_in = W_DATA'(d);
        tick(1);
        host_dv_in = 0;
    endtask

    task automatic both_wr(input int pch, input int pd, input int hch, input int hd);
        pid_dv_in = 1;  pid_chan_in = W_CHAN'(pch);  pid_data_in = W_DATA'(pd);
        host_dv_in = 1; host_chan_in = W_CHAN'(hch); host_data_in = W_DATA'(hd);
        tick(1);
        pid_dv_in = 0; host_dv_in = 0;
    endtask

    task automatic done_pulse();
        dac_done_in = 1;
        tick(1);
        dac_done_in = 0;
    endtask

    task automatic wait_dv(input string nm);
        bit ok;
        ok = 0;
        for (int i = 0; i < 64 && !ok; i++) begin
            tick(1);
            if (dac_dv_out === 1'b1) ok = 1;
        end
        chk({nm, "_dv_seen"}, 32'(ok), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1);
    end

    initial begin
        int n;
        int ov0;
        rst_in = 1'b1;
        #2 rst_in = 1'b0;
        started = 1;
        tick(3);
        chk("rst_dv",   32'(dac_dv_out), 32'd0);
        chk("rst_busy", 32'(busy_out),   32'd0);
        chk("rst_tmo",  32'(tmo_out),    32'd0);
        rst_in = 1'b1;
        tick(2);

        // 1: reset while waiting on the controller
        host_wr(3, 16'h3333);
        wait_dv("t1");
        chk("t1_chan", 32'(dac_chan_out), 32'd3);
        tick(2);
        pid_wr(5, 16'h5555);
        tick(3);
        #2 rst_in = 1'b0;
        #1;
        chk("t1_rst_busy", 32'(busy_out),     32'd0);
        chk("t1_rst_chan", 32'(dac_chan_out), 32'd0);
        chk("t1_rst_data", 32'(dac_data_out), 32'd0);
        tick(1);
        rst_in = 1'b1;
        n = iss_chan.size();
        tick(10);
        chk("t1_no_issue", 32'(iss_chan.size()), 32'(n));

        // 2: single PID write, fixed latency
        pid_wr(2, 16'h1234);
        chk("t2_dv_early", 32'(dac_dv_out), 32'd0);
        tick(1);
        chk("t2_dv",   32'(dac_dv_out),   32'd1);
        chk("t2_chan", 32'(dac_chan_out), 32'd2);
        chk("t2_data", 32'(dac_data_out), 32'h1234);
        chk("t2_busy", 32'(busy_out),     32'd1);
        tick(1);
        chk("t2_dv_pulse", 32'(dac_dv_out), 32'd0);
        tick(17);
        chk("t2_busy_wait", 32'(busy_out), 32'd1);
        done_pulse();
        chk("t2_busy_done", 32'(busy_out), 32'd0);
        chk("t2_data_hold", 32'(dac_data_out), 32'h1234);
        tick(2);

        // 3: coalescing during WAIT
        pid_wr(0, 16'h0100);
        wait_dv("t3a");
        tick(1);
`ifdef DAC_SCHED_OVWR_CNT_EN
        ov0 = int'(ovwr_cnt_out);
`else
        ov0 = 0;
`endif
        host_wr(5, 16'h0001);
        pid_wr(5, 16'h0002);
        host_wr(5, 16'h0003);
        tick(2);
        done_pulse();
        n = iss_chan.size();
        wait_dv("t3b");
        chk("t3_chan", 32'(dac_chan_out), 32'd5);
        chk("t3_data", 32'(dac_data_out), 32'h0003);
        tick(2);
        done_pulse();
        tick(10);
        chk("t3_one_issue", 32'(iss_chan.size()), 32'(n + 1));
`ifdef DAC_SCHED_OVWR_CNT_EN
        chk("t3_ovwr", 32'(int'(ovwr_cnt_out) - ov0), 32'd2);
`endif

        // 4: round-robin order after ch3
        host_wr(3, 16'h0333);
        wait_dv("t4a");
        tick(1);
        pid_wr(1, 16'h0111);
        both_wr(3, 16'h3330, 6, 16'h0666);
        tick(1);
        done_pulse();
        n = iss_chan.size();
        for (int i = 0; i < 3; i++) begin
            wait_dv("t4b");
            tick(2);
            done_pulse();
        end
        tick(2);
        if (iss_chan.size() >= n + 3) begin
            chk("t4_ord0", 32'(iss_chan[n]),   32'd6);
            chk("t4_ord1", 32'(iss_chan[n+1]), 32'd1);
            chk("t4_ord2", 32'(iss_chan[n+2]), 32'd3);
            chk("t4_dat0", 32'(iss_data[n]),   32'h0666);
            chk("t4_dat2", 32'(iss_data[n+2]), 32'h3330);
        end else begin
            chk("t4_count", 32'(iss_chan.size() - n), 32'd3);
        end

        // 5: host priority and hold mask
        both_wr(4, 16'hAAAA, 4, 16'h5555);
        wait_dv("t5a");
        chk("t5_prio", 32'(dac_data_out), 32'h5555);
        tick(2);
        done_pulse();
        hold_mask_in = N_CHAN'(1) << 4;
        n = iss_chan.size();
        pid_wr(4, 16'hBEEF);
        tick(8);
        chk("t5_hold", 32'(iss_chan.size()), 32'(n));
        host_wr(4, 16'h7777);
        wait_dv("t5b");
        chk("t5_host_chan", 32'(dac_chan_out), 32'd4);
        chk("t5_host_data", 32'(dac_data_out), 32'h7777);
        tick(2);
        done_pulse();
        hold_mask_in = '0;
        tick(2);

        // 6: watchdog and out-of-range channel
        pid_wr(7, 16'h0707);
        wait_dv("t6a");
        tick(2);
        pid_wr(2, 16'h2222);
        both_wr(9, 16'h9999, 9, 16'h9998);
        tick(TMO_WAIT - 4);
        chk("t6_tmo_before", 32'(tmo_out),  32'd0);
        chk("t6_busy_before", 32'(busy_out), 32'd1);
        tick(1);
        chk("t6_tmo",  32'(tmo_out),  32'd1);
        chk("t6_busy", 32'(busy_out), 32'd0);
        tick(1);
        chk("t6_next_dv",   32'(dac_dv_out),   32'd1);
        chk("t6_next_chan", 32'(dac_chan_out), 32'd2);
        chk("t6_next_data", 32'(dac_data_out), 32'h2222);
        tick(2);
        done_pulse();
        n = iss_chan.size();
        tick(10);
        chk("t6_ch9_ignored", 32'(iss_chan.size()), 32'(n));
        chk("t6_tmo_sticky",  32'(tmo_out), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
